// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures each high pulse, validates it, decodes the flag command and flags signal loss.
// Optional macro SERVO_DEC_HYST_EN: the command changes only after two consecutive agreeing valid pulses.
module servo_pwm_decoder #(
  parameter int unsigned CLK_FREQ_HZ    = 25_000_000,
  parameter int unsigned MIN_PULSE_CLKS = 12_500,
  parameter int unsigned MAX_PULSE_CLKS = 62_500,
  parameter int unsigned THRESHOLD_CLKS = 31_250,
  parameter int unsigned TIMEOUT_CLKS   = 750_000,
  parameter int unsigned COUNTER_BITS   = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pwm_in,
  output logic [COUNTER_BITS-1:0] pulse_width,
  output logic                    pulse_valid,
  output logic                    pulse_error,
  output logic                    comando_banderin,
  output logic                    signal_lost
);

  if (TIMEOUT_CLKS >= (64'd1 << COUNTER_BITS) || CLK_FREQ_HZ == 0) begin : g_param_check
    $error("servo_pwm_decoder: COUNTER_BITS cannot hold TIMEOUT_CLKS or CLK_FREQ_HZ is zero");
  end

  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, HIGH} state_e;

  localparam logic [COUNTER_BITS-1:0] MIN_W = COUNTER_BITS'(MIN_PULSE_CLKS);
  localparam logic [COUNTER_BITS-1:0] MAX_W = COUNTER_BITS'(MAX_PULSE_CLKS);
  localparam logic [COUNTER_BITS-1:0] THR_W = COUNTER_BITS'(THRESHOLD_CLKS);
  localparam logic [COUNTER_BITS-1:0] TMO_W = COUNTER_BITS'(TIMEOUT_CLKS);
  localparam logic [COUNTER_BITS-1:0] ONE_W = COUNTER_BITS'(1);

  state_e                  state_q, state_d;
  logic                    sync1_q, sync2_q, dly_q, rise_q, fall_q;
  logic [1:0]              settle_q;
  logic [COUNTER_BITS-1:0] width_q, width_d, pw_q, tmo_q, tmo_d;
  logic                    valid_d, error_d, valid_q, error_q;
  logic                    lost_q, lost_d, cmd_q, dec;

  // settle_q keeps WAIT_LOW from trusting the chain until it holds real samples,
  // so a pulse already high at reset release is never measured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      dly_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      rise_q  <= sync2_q & ~dly_q;
      fall_q  <= ~sync2_q & dly_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= WAIT_LOW;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOW:  if (settle_q == 2'd3 && !dly_q) state_d = WAIT_RISE;
      WAIT_RISE: if (rise_q) state_d = HIGH;
      HIGH: begin
        if (fall_q)                state_d = WAIT_RISE;
        else if (width_q == MAX_W) state_d = WAIT_LOW;
      end
      default:   state_d = WAIT_LOW;
    endcase
  end

  // Stopping at MAX_W gives exactly one error per overlong pulse and the counter never wraps.
  always_comb begin
    valid_d = 1'b0;
    error_d = 1'b0;
    width_d = width_q;
    case (state_q)
      WAIT_RISE: if (rise_q) width_d = ONE_W;
      HIGH: begin
        if (fall_q) begin
          if (width_q >= MIN_W) valid_d = 1'b1;
          else                  error_d = 1'b1;
        end else if (width_q == MAX_W) begin
          error_d = 1'b1;
        end else begin
          width_d = width_q + ONE_W;
        end
      end
      default: width_d = width_q;
    endcase
  end

  assign dec = (width_q >= THR_W);

  always_comb begin
    tmo_d  = (tmo_q == TMO_W) ? tmo_q : tmo_q + ONE_W;
    lost_d = lost_q | (tmo_d == TMO_W);
    if (valid_d) begin
      tmo_d  = '0;
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_q <= '0;
      pw_q    <= '0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      lost_q  <= 1'b1;
    end else begin
      width_q <= width_d;
      valid_q <= valid_d;
      error_q <= error_d;
      tmo_q   <= tmo_d;
      lost_q  <= lost_d;
      if (valid_d) pw_q <= width_q;
    end
  end

`ifdef SERVO_DEC_HYST_EN
  logic pend_q, agree_q;

  // A new command must be seen twice in a row; errors or signal loss break the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q   <= 1'b0;
      pend_q  <= 1'b0;
      agree_q <= 1'b0;
    end else if (valid_d) begin
      if (dec == cmd_q) begin
        agree_q <= 1'b0;
      end else if (agree_q && pend_q == dec) begin
        cmd_q   <= dec;
        agree_q <= 1'b0;
      end else begin
        pend_q  <= dec;
        agree_q <= 1'b1;
      end
    end else if (error_d || lost_q) begin
      agree_q <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cmd_q <= 1'b0;
    else if (valid_d) cmd_q <= dec;
  end
`endif

  assign pulse_width      = pw_q;
  assign pulse_valid      = valid_q;
  assign pulse_error      = error_q;
  assign comando_banderin = cmd_q;
  assign signal_lost      = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with limits scaled down (MIN 50, MAX 250, THRESHOLD 125, TIMEOUT 3000 clocks).
// Strobe timing is measured at negedges: a strobe 3 cycles after the first low sample lands 4 negedges (40 time units) after the fall is driven.
module tb_servo_pwm_decoder;

  localparam int CB   = 12;
  localparam int MINW = 50;
  localparam int MAXW = 250;
  localparam int THR  = 125;
  localparam int TMO  = 3000;
`ifdef SERVO_DEC_HYST_EN
  localparam bit HystEn = 1'b1;
`else
  localparam bit HystEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          pwm_in;
  logic [CB-1:0] pulse_width;
  logic          pulse_valid, pulse_error, comando_banderin, signal_lost;

  int  vectors = 0;
  int  miscompares = 0;
  int  validCount = 0;
  int  errorCount = 0;
  time lastValidTime = 0, lastErrorTime = 0, riseTime = 0, fallTime = 0;
  time lostRiseTime = 0, lostFallTime = 0;
  logic prevLost = 1'b1;

  always #5 clk = ~clk;

  servo_pwm_decoder #(
    .CLK_FREQ_HZ(25_000_000), .MIN_PULSE_CLKS(MINW), .MAX_PULSE_CLKS(MAXW),
    .THRESHOLD_CLKS(THR), .TIMEOUT_CLKS(TMO), .COUNTER_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .pulse_width(pulse_width),
    .pulse_valid(pulse_valid), .pulse_error(pulse_error),
    .comando_banderin(comando_banderin), .signal_lost(signal_lost)
  );

  // Strobe and signal_lost edge monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (pulse_valid === 1'b1) begin
      validCount++;
      lastValidTime = $time;
    end
    if (pulse_error === 1'b1) begin
      errorCount++;
      lastErrorTime = $time;
    end
    if (signal_lost === 1'b1 && prevLost === 1'b0) lostRiseTime = $time;
    if (signal_lost === 1'b0 && prevLost === 1'b1) lostFallTime = $time;
    prevLost = signal_lost;
  end

  task automatic applyStimulus(input int high, input int low);
    @(negedge clk);
    pwm_in = 1'b1;
    riseTime = $time;
    repeat (high) @(negedge clk);
    pwm_in = 1'b0;
    fallTime = $time;
    repeat (low) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (pulse_width !== 12'd0) begin miscompares++; $display("[TB] FAIL reset_width: got %0d expected 0", pulse_width); end
    vectors++; if (pulse_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", pulse_valid); end
    vectors++; if (pulse_error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_error: got %b expected 0", pulse_error); end
    vectors++; if (comando_banderin !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cmd: got %b expected 0", comando_banderin); end
    vectors++; if (signal_lost !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_lost: got %b expected 1", signal_lost); end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    vectors++; if (signal_lost !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_lost: got %b expected 1", signal_lost); end
    vectors++; if (validCount !== 0) begin miscompares++; $display("[TB] FAIL idle_valid_count: got %0d expected 0", validCount); end
  endtask

  task automatic test_frames();
    int  base = validCount;
    time firstValid = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(150, 1850);
      vectors++; if (validCount !== base + i + 1) begin miscompares++; $display("[TB] FAIL frame%0d_count: got %0d expected %0d", i, validCount, base + i + 1); end
      vectors++; if (lastValidTime - fallTime !== 40) begin miscompares++; $display("[TB] FAIL frame%0d_latency: got %0t expected 40", i, lastValidTime - fallTime); end
      vectors++; if (pulse_width !== 12'd150) begin miscompares++; $display("[TB] FAIL frame%0d_width: got %0d expected 150", i, pulse_width); end
      if (i == 0) firstValid = lastValidTime;
    end
    vectors++; if (comando_banderin !== 1'b1) begin miscompares++; $display("[TB] FAIL frames_cmd: got %b expected 1", comando_banderin); end
    vectors++; if (lostFallTime !== firstValid) begin miscompares++; $display("[TB] FAIL frames_lost_fall: got %0t expected %0t", lostFallTime, firstValid); end
    vectors++; if (signal_lost !== 1'b0) begin miscompares++; $display("[TB] FAIL frames_lost: got %b expected 0", signal_lost); end
  endtask

  task automatic test_switch();
    logic expCmd;
    applyStimulus(100, 1900);
    expCmd = HystEn ? 1'b1 : 1'b0;
    vectors++; if (pulse_width !== 12'd100) begin miscompares++; $display("[TB] FAIL switch1_width: got %0d expected 100", pulse_width); end
    vectors++; if (comando_banderin !== expCmd) begin miscompares++; $display("[TB] FAIL switch1_cmd: got %b expected %b", comando_banderin, expCmd); end
    applyStimulus(100, 1900);
    vectors++; if (pulse_width !== 12'd100) begin miscompares++; $display("[TB] FAIL switch2_width: got %0d expected 100", pulse_width); end
    vectors++; if (comando_banderin !== 1'b0) begin miscompares++; $display("[TB] FAIL switch2_cmd: got %b expected 0", comando_banderin); end
  endtask

  task automatic test_short_pulse();
    int baseV = validCount;
    int baseE = errorCount;
    applyStimulus(40, 1960);
    vectors++; if (errorCount !== baseE + 1) begin miscompares++; $display("[TB] FAIL short_error_count: got %0d expected %0d", errorCount, baseE + 1); end
    vectors++; if (validCount !== baseV) begin miscompares++; $display("[TB] FAIL short_valid_count: got %0d expected %0d", validCount, baseV); end
    vectors++; if (lastErrorTime - fallTime !== 40) begin miscompares++; $display("[TB] FAIL short_latency: got %0t expected 40", lastErrorTime - fallTime); end
    vectors++; if (pulse_width !== 12'd100) begin miscompares++; $display("[TB] FAIL short_width: got %0d expected 100", pulse_width); end
    vectors++; if (comando_banderin !== 1'b0) begin miscompares++; $display("[TB] FAIL short_cmd: got %b expected 0", comando_banderin); end
  endtask

  task automatic test_overlong();
    int   baseV = validCount;
    int   baseE = errorCount;
    logic expCmd;
    applyStimulus(400, 1600);
    vectors++; if (errorCount !== baseE + 1) begin miscompares++; $display("[TB] FAIL long_error_count: got %0d expected %0d", errorCount, baseE + 1); end
    vectors++; if (validCount !== baseV) begin miscompares++; $display("[TB] FAIL long_valid_count: got %0d expected %0d", validCount, baseV); end
    vectors++; if (lastErrorTime - riseTime !== 2540) begin miscompares++; $display("[TB] FAIL long_error_time: got %0t expected 2540", lastErrorTime - riseTime); end
    vectors++; if (pulse_width !== 12'd100) begin miscompares++; $display("[TB] FAIL long_width_hold: got %0d expected 100", pulse_width); end
    applyStimulus(150, 1850);
    expCmd = HystEn ? 1'b0 : 1'b1;
    vectors++; if (validCount !== baseV + 1) begin miscompares++; $display("[TB] FAIL after_long_count: got %0d expected %0d", validCount, baseV + 1); end
    vectors++; if (pulse_width !== 12'd150) begin miscompares++; $display("[TB] FAIL after_long_width: got %0d expected 150", pulse_width); end
    vectors++; if (comando_banderin !== expCmd) begin miscompares++; $display("[TB] FAIL after_long_cmd: got %b expected %b", comando_banderin, expCmd); end
    vectors++; if (signal_lost !== 1'b0) begin miscompares++; $display("[TB] FAIL after_long_lost: got %b expected 0", signal_lost); end
  endtask

  task automatic test_timeout();
    lostRiseTime = 0;
    applyStimulus(150, 3100);
    vectors++; if (lostRiseTime - lastValidTime !== TMO * 10) begin miscompares++; $display("[TB] FAIL timeout_delay: got %0t expected %0d", lostRiseTime - lastValidTime, TMO * 10); end
    vectors++; if (signal_lost !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_lost: got %b expected 1", signal_lost); end
    vectors++; if (pulse_width !== 12'd150) begin miscompares++; $display("[TB] FAIL timeout_width_hold: got %0d expected 150", pulse_width); end
    applyStimulus(150, 200);
    vectors++; if (lostFallTime !== lastValidTime) begin miscompares++; $display("[TB] FAIL recover_lost_fall: got %0t expected %0t", lostFallTime, lastValidTime); end
    vectors++; if (signal_lost !== 1'b0) begin miscompares++; $display("[TB] FAIL recover_lost: got %b expected 0", signal_lost); end
  endtask

  task automatic test_reset_mid();
    int baseV;
    int baseE;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (60) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    vectors++; if (pulse_width !== 12'd0) begin miscompares++; $display("[TB] FAIL midreset_width: got %0d expected 0", pulse_width); end
    vectors++; if (comando_banderin !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_cmd: got %b expected 0", comando_banderin); end
    vectors++; if (signal_lost !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_lost: got %b expected 1", signal_lost); end
    baseV = validCount;
    baseE = errorCount;
    reset = 1'b0;
    repeat (150) @(negedge clk);
    pwm_in = 1'b0;
    repeat (500) @(negedge clk);
    vectors++; if (validCount !== baseV) begin miscompares++; $display("[TB] FAIL midreset_no_valid: got %0d expected %0d", validCount, baseV); end
    vectors++; if (errorCount !== baseE) begin miscompares++; $display("[TB] FAIL midreset_no_error: got %0d expected %0d", errorCount, baseE); end
    applyStimulus(150, 500);
    vectors++; if (validCount !== baseV + 1) begin miscompares++; $display("[TB] FAIL midreset_next_count: got %0d expected %0d", validCount, baseV + 1); end
    vectors++; if (pulse_width !== 12'd150) begin miscompares++; $display("[TB] FAIL midreset_next_width: got %0d expected 150", pulse_width); end
  endtask

  task automatic test_boundaries();
    int highs[6]      = '{49, 50, 124, 125, 250, 251};
    bit isValid[6]    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int expWidth[6]   = '{150, 50, 124, 125, 250, 250};
    bit expCmd[6]     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit expCmdHyst[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      int baseV = validCount;
      int baseE = errorCount;
      logic cmdRef;
      applyStimulus(highs[i], 500);
      cmdRef = HystEn ? expCmdHyst[i] : expCmd[i];
      vectors++; if (validCount !== baseV + int'(isValid[i])) begin miscompares++; $display("[TB] FAIL bound%0d_valid: got %0d expected %0d", highs[i], validCount - baseV, isValid[i]); end
      vectors++; if (errorCount !== baseE + int'(!isValid[i])) begin miscompares++; $display("[TB] FAIL bound%0d_error: got %0d expected %0d", highs[i], errorCount - baseE, !isValid[i]); end
      vectors++; if (pulse_width !== CB'(expWidth[i])) begin miscompares++; $display("[TB] FAIL bound%0d_width: got %0d expected %0d", highs[i], pulse_width, expWidth[i]); end
      vectors++; if (comando_banderin !== cmdRef) begin miscompares++; $display("[TB] FAIL bound%0d_cmd: got %b expected %b", highs[i], comando_banderin, cmdRef); end
    end
  endtask

  initial begin
    reset = 1'b1;
    pwm_in = 1'b0;
    $display("[TB] starting servo_pwm_decoder bench (hysteresis build: %0d)", HystEn);
    test_reset();
    test_frames();
    test_switch();
    test_short_pulse();
    test_overlong();
    test_timeout();
    test_reset_mid();
    test_boundaries();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
